// File: rtl/seq_alu.sv
// Multi-cycle ALU: compare, subtract-with-carry, radix-4 Booth and shift-add multiply.
// Operands latch on a start/busy/done handshake; F/Cout are registered and held.
module seq_alu #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     S,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  input  logic           Cin,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] F,
  output logic           Cout
);

  localparam int CW = $clog2(W + 2);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  last_c;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W:0]     m_q, m_d;
  logic           cin_q, cin_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] f_q, f_d;
  logic           cout_q, cout_d;

  logic           accept;
  logic [W-1:0]   y_op;
  logic [W:0]     sum;
  logic [2*W-1:0] xs;
  logic [2*W-1:0] pp;
  logic [W:0]     hi;

  // m_q holds {Y,0}; top three bits form the current Booth window
  assign y_op = m_q[W:1];
  assign xs   = {{W{a_q[W-1]}}, a_q};
  assign hi   = acc_q[2*W-1:W-1];
  assign sum  = {1'b0, a_q} + {1'b0, (~y_op) + 1'b1}
              + {{W{1'b0}}, cin_q};

  always_comb begin
    pp = '0;
    unique case (m_q[W:W-2])
      3'b001, 3'b010: pp = xs;
      3'b011:         pp = xs << 1;
      3'b100:         pp = -(xs << 1);
      3'b101, 3'b110: pp = -xs;
      default:        pp = '0;
    endcase
  end

  always_comb begin
    last_c = '0;
    unique case (op_q)
      2'b10:   last_c = CW'(W / 2);
      2'b11:   last_c = CW'(W);
      default: last_c = '0;
    endcase
  end

  assign accept = start && (state_q != EXEC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    m_d     = m_q;
    cin_d   = cin_q;
    acc_d   = acc_q;
    f_d     = f_q;
    cout_d  = cout_q;
    if (state_q == EXEC) begin
      if (cnt_q == last_c) begin
        state_d = DONE;
        unique case (op_q)
          2'b00: begin
            f_d    = '0;
            cout_d = (a_q <= y_op);
          end
          2'b01: begin
            f_d    = {{W{1'b0}}, sum[W-1:0]};
            cout_d = sum[W];
          end
          2'b10: begin
            f_d    = acc_q;
            cout_d = !((&hi) || !(|hi));
          end
          default: begin
            f_d    = acc_q;
            cout_d = |acc_q[2*W-1:W];
          end
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == 2'b10) begin
          acc_d = (acc_q << 2) + pp;
          m_d   = m_q << 2;
        end else if (op_q == 2'b11) begin
          acc_d = (acc_q << 1)
                + (m_q[W] ? {{W{1'b0}}, a_q} : '0);
          m_d   = m_q << 1;
        end
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    if (accept) begin
      state_d = EXEC;
      cnt_d   = '0;
      op_d    = S;
      a_d     = X;
      m_d     = {Y, 1'b0};
      cin_d   = Cin;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      m_q     <= '0;
      cin_q   <= 1'b0;
      acc_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      m_q     <= m_d;
      cin_q   <= cin_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == EXEC);
  assign done = (state_q == DONE);
  assign F    = f_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed spec vectors, reset abort, disturbance
// and randomized ops checked against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  S = '0;
  logic [7:0]  X = '0;
  logic [7:0]  Y = '0;
  logic        Cin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] F;
  logic        Cout;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] last_res = '0;

  seq_alu #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .S    (S),
    .X    (X),
    .Y    (Y),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .F    (F),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lat(input logic [1:0] s);
    case (s)
      2'b10:   return W / 2 + 1;
      2'b11:   return W + 1;
      default: return 1;
    endcase
  endfunction

  // {Cout, F} from plain integer arithmetic
  function automatic logic [16:0] ref_res(input logic [1:0] s,
                                          input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic c);
    int p;
    logic [16:0] r;
    r = '0;
    case (s)
      2'b00: r = {(x <= y), 16'h0000};
      2'b01: begin
        p = int'(x) + ((256 - int'(y)) % 256) + int'(c);
        r = {p[8], 8'h00, p[7:0]};
      end
      2'b10: begin
        p = int'($signed(x)) * int'($signed(y));
        r = {(p > 127 || p < -128), p[15:0]};
      end
      default: begin
        p = int'(x) * int'(y);
        r = {(p > 255), p[15:0]};
      end
    endcase
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the DONE cycle
  task automatic do_op(input logic [1:0] s, input logic [7:0] x,
                       input logic [7:0] y, input logic c,
                       input bit disturb, input string tag);
    logic [16:0] e;
    int lat;
    int bc;
    int l;
    e = ref_res(s, x, y, c);
    l = ref_lat(s);
    start = 1'b1;
    S = s;
    X = x;
    Y = y;
    Cin = c;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      if (disturb) begin
        X = 8'($urandom);
        Y = 8'($urandom);
        S = 2'($urandom);
        Cin = 1'($urandom);
        start = (lat == 2);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(l));
    chk({tag, " busy_cycles"}, 32'(bc), 32'(l));
    chk({tag, " F"}, 32'(F), 32'(e[15:0]));
    chk({tag, " Cout"}, 32'(Cout), 32'(e[16]));
    last_res = e;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk({tag, " done_low"}, 32'(done), 32'd0);
      chk({tag, " busy_low"}, 32'(busy), 32'd0);
      chk({tag, " F_hold"}, 32'(F), 32'(last_res[15:0]));
      chk({tag, " Cout_hold"}, 32'(Cout), 32'(last_res[16]));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset F", 32'(F), 32'd0);
    chk("reset Cout", 32'(Cout), 32'd0);
    rst_n = 1'b1;
    last_res = '0;

    do_op(2'b00, 8'd5, 8'd5, 1'b0, 1'b0, "cmp_eq");
    chk("cmp_eq spec", {15'd0, Cout, F}, 32'h0001_0000);
    idle(1, "cmp_eq idle");
    do_op(2'b00, 8'd6, 8'd5, 1'b0, 1'b0, "cmp_gt");
    do_op(2'b01, 8'd3, 8'd5, 1'b0, 1'b0, "sub_a");
    chk("sub_a spec", {15'd0, Cout, F}, 32'h0000_00FE);
    do_op(2'b01, 8'd5, 8'd3, 1'b1, 1'b0, "sub_b");
    chk("sub_b spec", {15'd0, Cout, F}, 32'h0001_0003);
    do_op(2'b01, 8'd9, 8'd0, 1'b1, 1'b0, "sub_y0");
    do_op(2'b10, 8'hF9, 8'd6, 1'b0, 1'b0, "booth_a");
    chk("booth_a spec", {15'd0, Cout, F}, 32'h0000_FFD6);
    do_op(2'b10, 8'h80, 8'h80, 1'b0, 1'b0, "booth_b");
    chk("booth_b spec", {15'd0, Cout, F}, 32'h0001_4000);
    do_op(2'b10, 8'h7F, 8'h81, 1'b0, 1'b0, "booth_c");
    do_op(2'b11, 8'hFF, 8'hFF, 1'b0, 1'b0, "mul_ff");
    chk("mul_ff spec", {15'd0, Cout, F}, 32'h0001_FE01);
    idle(2, "mul_ff idle");

    do_op(2'b11, 8'hA5, 8'h3C, 1'b0, 1'b1, "disturb");
    do_op(2'b00, 8'd6, 8'd5, 1'b0, 1'b0, "b2b");
    idle(12, "no_queue");

    start = 1'b1;
    S = 2'b10;
    X = 8'h35;
    Y = 8'hC7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort F", 32'(F), 32'd0);
    chk("abort Cout", 32'(Cout), 32'd0);
    last_res = '0;
    idle(6, "abort");
    do_op(2'b11, 8'd3, 8'd4, 1'b0, 1'b0, "post_abort");
    chk("post_abort spec", 32'(F), 32'd12);

    for (int i = 0; i < 60; i++) begin
      do_op(2'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'b0, "rand");
      if ($urandom_range(0, 1) == 1) idle(1, "rand idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
